// File: rtl/pe_tick_mac_if.sv
// Operand intake, result output and status signals of the tick-paced MAC.
// master drives operands and consumes results; slave is the MAC itself.
interface pe_tick_mac_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24
);
    logic              tick;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;
    logic              busy;

    modport master (
        output tick, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );

    modport slave (
        input  tick, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );
endinterface

// File: rtl/pe_tick_mac.sv
// Tick-paced multiply-accumulate: takes at most one signed pair per tick, sums LEN
// products, then holds the result on a valid/ready port until it is taken.
module pe_tick_mac #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned LEN    = 4
) (
    input logic          clk,
    input logic          rst,
    pe_tick_mac_if.slave bus
);
    localparam int unsigned CNT_W  = $clog2(LEN + 1);
    localparam int unsigned PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ovf_q;
    logic                    out_ovf_q;
    logic                    out_valid_q;
    logic                    busy_q;

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_next;
    logic                     add_ovf;
    logic                     xfer;
    logic                     last;

    always_comb begin
        a_ext    = PROD_W'($signed(bus.in_a));
        b_ext    = PROD_W'($signed(bus.in_b));
        prod     = a_ext * b_ext;
        prod_ext = ACC_W'(prod);
        acc_next = acc_q + prod_ext;
        // Same-sign operands producing an opposite-sign result means the add wrapped.
        add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (acc_next[ACC_W-1] != acc_q[ACC_W-1]);
    end

    assign bus.in_ready  = bus.tick && (state_q != StDone);
    assign xfer          = bus.in_valid && bus.in_ready;
    assign last          = (cnt_q == CNT_W'(LEN - 1));

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            sum_q       <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (xfer) begin
                        acc_q  <= prod_ext;
                        cnt_q  <= CNT_W'(1);
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (LEN == 1) begin
                            state_q     <= StDone;
                            sum_q       <= prod_ext;
                            out_ovf_q   <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (xfer) begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                        ovf_q <= ovf_q | add_ovf;
                        if (last) begin
                            state_q     <= StDone;
                            sum_q       <= acc_next;
                            out_ovf_q   <= ovf_q | add_ovf;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_tick_mac.sv
// Directed bench for pe_tick_mac: default config, a 16-bit accumulator config for
// overflow, and a LEN=1 config driven with tick held high.
module tb_pe_tick_mac;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pe_tick_mac_if #(.DATA_W(8), .ACC_W(24)) bus0 ();
    pe_tick_mac_if #(.DATA_W(8), .ACC_W(16)) bus1 ();
    pe_tick_mac_if #(.DATA_W(8), .ACC_W(24)) bus2 ();

    pe_tick_mac #(.DATA_W(8), .ACC_W(24), .LEN(4)) u_def  (.clk(clk), .rst(rst), .bus(bus0));
    pe_tick_mac #(.DATA_W(8), .ACC_W(16), .LEN(4)) u_ovf  (.clk(clk), .rst(rst), .bus(bus1));
    pe_tick_mac #(.DATA_W(8), .ACC_W(24), .LEN(1)) u_len1 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // 11 cycles without tick, then one tick cycle; in_valid/operands held throughout.
    task automatic tick_cycle0(input logic v, input int a, input int b);
        bus0.tick     = 1'b0;
        bus0.in_valid = v;
        bus0.in_a     = 8'(a);
        bus0.in_b     = 8'(b);
        repeat (11) step();
        bus0.tick = 1'b1;
        step();
        bus0.tick = 1'b0;
    endtask

    task automatic drive_fast1(input int a, input int b, input int n);
        bus1.tick     = 1'b1;
        bus1.in_valid = 1'b1;
        bus1.in_a     = 8'(a);
        bus1.in_b     = 8'(b);
        repeat (n) step();
        bus1.tick     = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    initial begin
        bus0.tick = 0; bus0.in_valid = 0; bus0.in_a = 0; bus0.in_b = 0; bus0.out_ready = 1;
        bus1.tick = 0; bus1.in_valid = 0; bus1.in_a = 0; bus1.in_b = 0; bus1.out_ready = 1;
        bus2.tick = 0; bus2.in_valid = 0; bus2.in_a = 0; bus2.in_b = 0; bus2.out_ready = 1;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_out_sum", $signed(bus0.out_sum), 0);
        check("rst_out_ovf", bus0.out_ovf, 0);
        check("rst_busy", bus0.busy, 0);
        check("rst_in_ready_notick", bus0.in_ready, 0);
        bus0.tick = 1'b1;
        #1;
        check("rst_in_ready_tick", bus0.in_ready, 1);
        bus0.tick = 1'b0;
        step();

        // Basic group: 2 + 12 - 30 - 56 = -72
        tick_cycle0(1'b1, 1, 2);
        check("basic_busy", bus0.busy, 1);
        tick_cycle0(1'b1, 3, 4);
        tick_cycle0(1'b1, -5, 6);
        check("basic_not_done", bus0.out_valid, 0);
        tick_cycle0(1'b1, 7, -8);
        bus0.in_valid = 1'b0;
        check("basic_out_valid", bus0.out_valid, 1);
        check("basic_sum", $signed(bus0.out_sum), -72);
        check("basic_ovf", bus0.out_ovf, 0);
        step();
        check("basic_valid_one_cycle", bus0.out_valid, 0);
        check("basic_busy_after", bus0.busy, 0);
        check("basic_sum_held", $signed(bus0.out_sum), -72);

        // Bubbles on ticks 2 and 3: result 16 only after the 6th tick
        tick_cycle0(1'b1, 2, 2);
        tick_cycle0(1'b0, 2, 2);
        tick_cycle0(1'b0, 2, 2);
        tick_cycle0(1'b1, 2, 2);
        tick_cycle0(1'b1, 2, 2);
        check("bubble_not_done", bus0.out_valid, 0);
        tick_cycle0(1'b1, 2, 2);
        bus0.in_valid = 1'b0;
        check("bubble_out_valid", bus0.out_valid, 1);
        check("bubble_sum", $signed(bus0.out_sum), 16);
        step();

        // Output stall: result 12 held while two ticks with valid pairs are lost
        bus0.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick_cycle0(1'b1, 1, 3);
        check("stall_out_valid", bus0.out_valid, 1);
        for (int i = 0; i < 30; i++) begin
            bus0.tick     = (i == 10 || i == 20);
            bus0.in_valid = 1'b1;
            bus0.in_a     = 8'd5;
            bus0.in_b     = 8'd5;
            #1;
            if (i == 10 || i == 20) check("stall_in_ready", bus0.in_ready, 0);
            step();
        end
        bus0.tick = 1'b0;
        check("stall_valid_held", bus0.out_valid, 1);
        check("stall_sum_held", $signed(bus0.out_sum), 12);
        bus0.out_ready = 1'b1;
        bus0.tick      = 1'b1;
        #1;
        check("hs_in_ready", bus0.in_ready, 0);
        step();
        bus0.tick     = 1'b0;
        bus0.in_valid = 1'b0;
        check("hs_valid_drop", bus0.out_valid, 0);
        for (int i = 0; i < 4; i++) tick_cycle0(1'b1, 2, 1);
        bus0.in_valid = 1'b0;
        check("after_stall_valid", bus0.out_valid, 1);
        check("after_stall_sum", $signed(bus0.out_sum), 8);
        check("after_stall_ovf", bus0.out_ovf, 0);
        step();

        // Reset after 2 transfers discards the partial sum
        tick_cycle0(1'b1, 1, 1);
        tick_cycle0(1'b1, 1, 1);
        bus0.in_valid = 1'b0;
        check("pre_rst_busy", bus0.busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", bus0.busy, 0);
        check("mid_rst_out_valid", bus0.out_valid, 0);
        for (int i = 0; i < 4; i++) tick_cycle0(1'b1, 1, 1);
        bus0.in_valid = 1'b0;
        check("post_rst_valid", bus0.out_valid, 1);
        check("post_rst_sum", $signed(bus0.out_sum), 4);
        step();

        // Overflow: 4 * 16129 = 64516 wraps to -1020 in 16 bits
        drive_fast1(127, 127, 4);
        check("ovf_out_valid", bus1.out_valid, 1);
        check("ovf_sum", $signed(bus1.out_sum), -1020);
        check("ovf_flag", bus1.out_ovf, 1);
        step();
        check("ovf_valid_drop", bus1.out_valid, 0);
        drive_fast1(1, 1, 4);
        check("ovf_next_valid", bus1.out_valid, 1);
        check("ovf_next_sum", $signed(bus1.out_sum), 4);
        check("ovf_next_flag", bus1.out_ovf, 0);
        step();

        // LEN=1 with tick held high: DONE blocks input for one cycle
        bus2.tick     = 1'b1;
        bus2.in_valid = 1'b1;
        bus2.in_a     = 8'(3);
        bus2.in_b     = 8'(-3);
        #1;
        check("len1_ready_idle", bus2.in_ready, 1);
        step();
        check("len1_valid_a", bus2.out_valid, 1);
        check("len1_sum_a", $signed(bus2.out_sum), -9);
        bus2.in_a = 8'(2);
        bus2.in_b = 8'(5);
        #1;
        check("len1_ready_done", bus2.in_ready, 0);
        step();
        check("len1_gap_valid", bus2.out_valid, 0);
        check("len1_ready_again", bus2.in_ready, 1);
        step();
        bus2.in_valid = 1'b0;
        check("len1_valid_b", bus2.out_valid, 1);
        check("len1_sum_b", $signed(bus2.out_sum), 10);
        step();
        check("len1_valid_drop", bus2.out_valid, 0);
        bus2.tick = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_tick_mac.md
# pe_tick_mac

Tick-paced multiply-accumulate sequencer for the processing element, directly downstream of the clock-divider stage. The divider stage supplies a one-cycle `tick` strobe once per divided period. This block accepts at most one signed operand pair per tick and accumulates `LEN` products. It then presents the sum on a valid/ready output port and waits for it to be taken before starting the next group.

## Interface
- `DATA_W`, default 8: width of signed operands `in_a` and `in_b`.
- `ACC_W`, default 24: width of the signed accumulator and `out_sum`. Must be at least 2*DATA_W.
- `LEN`, default 4: products per result. Must be at least 1.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `tick`  in  1  one-cycle strobe from the divider stage; paces operand intake.
- `in_valid`  in  1  operand pair available.
- `in_ready`  out  1  block accepts the pair this cycle (combinational).
- `in_a`, `in_b`  in  DATA_W each  signed operands.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  ACC_W  signed accumulated sum.
- `out_ovf`  out  1  signed overflow occurred while forming `out_sum`.
- `busy`  out  1  high in the RUN and DONE states.

## Operation
- Transfer: a transfer happens when `in_valid && in_ready`.
- `in_ready`: equals `tick && (state==IDLE || state==RUN)`. It is never high in DONE.
- Product: `in_a*in_b` is a signed full-width product, sign-extended to ACC_W.
- Addition: ACC_W two's-complement, wraps on overflow.
  - Overflow is detected from the operand signs versus the result sign.
  - `ovf` is sticky for the current group.
- IDLE:
  - On a transfer: `acc <= product`, `cnt <= 1`, `ovf <= 0`.
  - Next state is DONE if LEN==1, otherwise RUN.
- RUN:
  - On a transfer: `acc <= acc + product`, `cnt <= cnt+1`, `ovf |= overflow`.
  - When the transfer makes `cnt==LEN`, go to DONE.
- Bubbles: a tick without `in_valid`, or `in_valid` without a tick, causes no transfer and no state change. There is no timeout.
- DONE:
  - `out_valid=1`.
  - `out_sum` and `out_ovf` are registered and hold stable until the handshake.
  - When `out_ready` is high, go to IDLE and deassert `out_valid` the next cycle.
- Reset values:
  - State IDLE; `acc`, `cnt`, `ovf` all 0.
  - `out_valid=0`, `out_sum=0`, `out_ovf=0`, `busy=0`.
  - `in_ready` follows `tick` from the first cycle after reset.
- Reset mid-group or during DONE: the partial sum or pending result is discarded and no output is produced.
- `out_sum` keeps its last value after the handshake until the next result is loaded.

## Timing
- Result latency: `out_valid` rises on the clock edge that registers the LEN-th transfer, i.e. it is visible the cycle after that transfer.
- Input throughput: at most one pair per tick. A group needs at least LEN ticks.
- Output stall: no input is accepted while DONE is stalled (`out_ready` low).
  - A tick that falls in DONE is lost; no transfer occurs on it.
- Handshake cycle: on the `out_ready` handshake cycle `in_ready` is 0, even if `tick` is 1.
  - The earliest next-group transfer is on a tick in the following cycle or later.
- `out_ready` outside DONE has no effect.
- `tick` held high continuously: the block accepts one pair per cycle. This mode is legal and is used for test acceleration.
- `cnt` width is clog2(LEN+1). `cnt` never exceeds LEN.

## Test plan
- Basic group: LEN=4, tick every 12 clk, pairs (1,2),(3,4),(-5,6),(7,-8), `out_ready=1`.
  - Expect `out_sum = 2+12-30-56 = -72`, `out_ovf=0`.
  - `out_valid` high for exactly 1 cycle, the cycle after the 4th tick transfer.
- Bubbles: `in_valid` low on ticks 2 and 3, then pairs (2,2) ×4.
  - Expect the result 16 only after 6 ticks.
  - `cnt` and `acc` unchanged across the bubble ticks.
- Output stall: hold `out_ready=0` for 30 cycles with 2 ticks in that window.
  - Expect `in_ready=0` throughout and `out_sum` stable.
  - On release, the next group starts at the first tick after the handshake.
- Overflow: ACC_W=16, DATA_W=8, LEN=4, pairs (127,127) ×4.
  - Expect the wrapped sum 64516 mod 65536 = -1020, and `out_ovf=1`.
  - The next group (1,1) ×4 gives 4 with `out_ovf=0`.
- Reset: assert `rst` for 1 cycle after 2 transfers.
  - Expect `busy=0` and `out_valid=0` the next cycle.
  - A fresh group of (1,1) ×4 then yields 4, not 6.
- LEN=1 with `tick` constantly high: pairs (3,-3),(2,5) back-to-back with `out_ready=1`.
  - Results -9 then 10.
  - One idle cycle between acceptances, because DONE blocks input.
